// File: rtl/segasys1_hiscore_arb.sv
// segasys1_hiscore_arb
//   Serialises hiscore loader byte accesses onto the SEGASYSTEM1 hiscore
//   ports (HSAD/HSDI/HSWE/HSDO). For each request it raises pause_req. It then
//   waits for a safe window, either a confirmed pause or an active VBLK when
//   VBLK_OK is set. Next it strobes the selected RAM or samples its read data,
//   and finishes with a one-clock ack.
//
// Ports
//   clk40M, reset            clock, async active-high reset
//   req/req_we/req_addr/
//   req_wdata                one byte request, sampled only while idle
//   ack, rdata, busy         completion pulse, read data (held), activity
//   pause_req, paused, vblk  core pause handshake and vertical blank
//   hsad, hsdi               shared RAM address / write data
//   hswe_main, hswe_video    per-target write strobes
//   hsdo_main, hsdo_video    per-target read data
//
// Address [15:12]==4'hC targets main work RAM; everything else is video RAM.

module segasys1_hiscore_arb #(
  parameter int unsigned RD_LAT     = 2,   // 1..7
  parameter int unsigned PAUSE_HOLD = 64,  // 0..255
  parameter bit          VBLK_OK    = 1'b1
) (
  input  logic        clk40M,
  input  logic        reset,
  input  logic        req,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        pause_req,
  input  logic        paused,
  input  logic        vblk,
  output logic [15:0] hsad,
  output logic [7:0]  hsdi,
  output logic        hswe_main,
  output logic        hswe_video,
  input  logic [7:0]  hsdo_main,
  input  logic [7:0]  hsdo_video
);

  localparam logic [2:0] RD_LAT_L = 3'(RD_LAT);
  localparam logic [7:0] HOLD_L   = 8'(PAUSE_HOLD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_WIN,
    S_ACCESS,
    S_WAIT_RD,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic        sel_main_q, sel_main_d;
  logic [15:0] hsad_q, hsad_d;       // doubles as the address latch
  logic [7:0]  hsdi_q, hsdi_d;       // doubles as the write data latch
  logic [2:0]  lat_q, lat_d;
  logic [7:0]  hold_q, hold_d;
  logic        ack_q, ack_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        pause_req_q, pause_req_d;
  logic        hswe_main_q, hswe_main_d;
  logic        hswe_video_q, hswe_video_d;

  logic win;

  assign win = paused | (VBLK_OK & vblk);

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    sel_main_d   = sel_main_q;
    hsad_d       = hsad_q;
    hsdi_d       = hsdi_q;
    lat_d        = lat_q;
    hold_d       = hold_q;
    ack_d        = 1'b0;
    rdata_d      = rdata_q;
    pause_req_d  = pause_req_q;
    hswe_main_d  = 1'b0;
    hswe_video_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d        = req_we;
          hsad_d      = req_addr;
          hsdi_d      = req_wdata;
          sel_main_d  = (req_addr[15:12] == 4'hC);
          pause_req_d = 1'b1;
          state_d     = S_WAIT_WIN;
        end else begin
          if (hold_q != 8'd0) hold_d = hold_q - 8'd1;
          // Registered output: drop pause_req together with the counter
          // reaching zero, so it falls PAUSE_HOLD+1 clocks after ack.
          pause_req_d = (hold_q > 8'd1);
        end
      end
      S_WAIT_WIN: begin
        if (win) begin
          state_d = S_ACCESS;
          // Strobe is registered, so it is raised on entry to ACCESS and
          // lasts exactly the one ACCESS clock.
          if (we_q) begin
            hswe_main_d  = sel_main_q;
            hswe_video_d = !sel_main_q;
          end
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          ack_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          lat_d   = RD_LAT_L;
          state_d = S_WAIT_RD;
        end
      end
      S_WAIT_RD: begin
        if (lat_q == 3'd1) begin
          rdata_d = sel_main_q ? hsdo_main : hsdo_video;
          ack_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      S_DONE: begin
        hold_d      = HOLD_L;
        pause_req_d = (HOLD_L != 8'd0);
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk40M or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      sel_main_q   <= 1'b0;
      hsad_q       <= '0;
      hsdi_q       <= '0;
      lat_q        <= '0;
      hold_q       <= '0;
      ack_q        <= 1'b0;
      rdata_q      <= '0;
      busy_q       <= 1'b0;
      pause_req_q  <= 1'b0;
      hswe_main_q  <= 1'b0;
      hswe_video_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      sel_main_q   <= sel_main_d;
      hsad_q       <= hsad_d;
      hsdi_q       <= hsdi_d;
      lat_q        <= lat_d;
      hold_q       <= hold_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      busy_q       <= busy_d;
      pause_req_q  <= pause_req_d;
      hswe_main_q  <= hswe_main_d;
      hswe_video_q <= hswe_video_d;
    end
  end

  assign ack        = ack_q;
  assign rdata      = rdata_q;
  assign busy       = busy_q;
  assign pause_req  = pause_req_q;
  assign hsad       = hsad_q;
  assign hsdi       = hsdi_q;
  assign hswe_main  = hswe_main_q;
  assign hswe_video = hswe_video_q;

endmodule

// File: tb/tb_segasys1_hiscore_arb.sv
// Bench for segasys1_hiscore_arb: directed vector table, hand-written corner
// sequences (long wait on vblk, back-to-back, reset mid-read, req while busy),
// then random transactions checked against a transaction-level memory model.
`timescale 1ns/1ps

module tb_segasys1_hiscore_arb;

  localparam int RDL = 2;
  localparam int PH  = 64;

  logic        clk40M = 1'b0;
  logic        reset;
  logic        req, req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        ack, busy, pause_req, paused, vblk;
  logic [7:0]  rdata, hsdi, hsdo_main, hsdo_video;
  logic [15:0] hsad;
  logic        hswe_main, hswe_video;

  always #10 clk40M = ~clk40M;

  segasys1_hiscore_arb #(.RD_LAT(RDL), .PAUSE_HOLD(PH), .VBLK_OK(1'b1)) dut (
    .clk40M(clk40M), .reset(reset), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .rdata(rdata),
    .busy(busy), .pause_req(pause_req), .paused(paused), .vblk(vblk),
    .hsad(hsad), .hsdi(hsdi), .hswe_main(hswe_main), .hswe_video(hswe_video),
    .hsdo_main(hsdo_main), .hsdo_video(hsdo_video));

  // ---------------- RAM models: contents = init pattern overlaid by writes
  logic [7:0] main_w  [logic [15:0]];
  logic [7:0] video_w [logic [15:0]];
  logic [7:0] d1m, d2m, d1v, d2v;

  function automatic logic [7:0] ram_rd(input logic m, input logic [15:0] a);
    if (m) return main_w.exists(a) ? main_w[a] : (a[7:0] ^ 8'h5A);
    return video_w.exists(a) ? video_w[a] : (a[7:0] ^ 8'h3C);
  endfunction

  // Read data valid RDL (=2) clocks after the address is presented.
  always @(posedge clk40M) begin
    d1m <= ram_rd(1'b1, hsad);
    d1v <= ram_rd(1'b0, hsad);
    d2m <= d1m;
    d2v <= d1v;
    if (hswe_main)  main_w[hsad]  = hsdi;
    if (hswe_video) video_w[hsad] = hsdi;
  end
  assign hsdo_main  = d2m;
  assign hsdo_video = d2v;

  // ---------------- reference model: one flat byte space, target by address
  logic [7:0] ref_mem [logic [15:0]];

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return (a[15:12] == 4'hC) ? (a[7:0] ^ 8'h5A) : (a[7:0] ^ 8'h3C);
  endfunction

  int          total = 0, bad = 0;
  int          since_ack = 1000;
  logic [15:0] last_addr = '0;
  logic [7:0]  last_rd = '0;
  logic        p0;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk40M);
    #1;
  endtask

  task automatic drive_win(input int c, input int d, input logic vb);
    logic w;
    w = (c >= 1 + d);
    if (vb) begin paused = 1'b0; vblk = w; end
    else    begin paused = w;    vblk = 1'b0; end
  endtask

  // Idle gap: pause_req must stay high for PH clocks after ack, then fall;
  // nothing else may move. fall = gap index of first low pause_req (-1 none).
  task automatic idle(input int n, output int fall);
    bit pok = 1, qok = 1;
    fall = -1;
    for (int i = 0; i < n; i++) begin
      tick();
      req = 1'b0; paused = 1'b0; vblk = 1'b0;
      @(negedge clk40M);
      since_ack++;
      if (pause_req !== (since_ack <= PH)) pok = 0;
      if (fall < 0 && pause_req === 1'b0) fall = since_ack;
      if (ack !== 1'b0 || busy !== 1'b0 || hswe_main !== 1'b0 ||
          hswe_video !== 1'b0 || hsad !== last_addr) qok = 0;
    end
    chk("idle_pause", int'(pok), 1);
    chk("idle_quiet", int'(qok), 1);
  endtask

  // One transaction. d = clocks with the window closed after the request
  // clock; vb = window via vblk instead of paused; xreq = clock at which a
  // stray req is pulsed (0 = none).
  task automatic run_txn(input logic we, input logic [15:0] a, input logic [7:0] wd,
                         input int d, input logic vb, input int xreq,
                         input int exp_lat, input logic [7:0] exp_rd);
    int         ack_c = -1, nm = 0, nv = 0, scyc = -1;
    bit         ad_ok = 1, pz_ok = 1, bz_ok = 1;
    logic [7:0] got_rd = '0;
    logic       sel;
    sel = (a[15:12] == 4'hC);
    tick();
    req = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    drive_win(0, d, vb);
    @(negedge clk40M);
    p0 = pause_req;
    for (int c = 1; c <= 400 && ack_c < 0; c++) begin
      tick();
      req = (c == xreq);
      if (c == xreq) begin req_addr = a ^ 16'h1000; req_wdata = ~wd; req_we = ~we; end
      drive_win(c, d, vb);
      @(negedge clk40M);
      if (hswe_main === 1'b1)  nm++;
      if (hswe_video === 1'b1) nv++;
      if (hswe_main === 1'b1 || hswe_video === 1'b1) begin
        scyc = c;
        if (hsad !== a || hsdi !== wd) ad_ok = 0;
      end
      if (pause_req !== 1'b1) pz_ok = 0;
      if (busy !== 1'b1) bz_ok = 0;
      if (ack === 1'b1) begin ack_c = c; got_rd = rdata; end
    end
    req = 1'b0;
    chk("ack_seen", int'(ack_c >= 0), 1);
    chk("latency", ack_c, exp_lat);
    chk("strobe_main", nm, int'(we && sel));
    chk("strobe_video", nv, int'(we && !sel));
    if (we) begin
      chk("strobe_cycle", scyc, 2 + d);
      chk("strobe_addr_data", int'(ad_ok), 1);
      chk("rdata_held", int'(got_rd), int'(last_rd));
    end else begin
      chk("rdata", int'(got_rd), int'(exp_rd));
      last_rd = exp_rd;
    end
    chk("pause_held", int'(pz_ok), 1);
    chk("busy_held", int'(bz_ok), 1);
    since_ack = 0;
    last_addr = a;
  endtask

  typedef struct {
    logic        we;
    logic [15:0] a;
    logic [7:0]  wd;
    int          d;
    logic        vb;
    int          lat;
    logic [7:0]  rd;
  } vec_t;

  vec_t tbl [14];
  logic [7:0] his [6] = '{8'hC0, 8'hCF, 8'hD0, 8'h80, 8'h00, 8'hC3};

  initial begin
    int f, nack;
    //            we    addr      wdata  d  vb    lat  rdata
    tbl[0]  = '{1'b1, 16'hC123, 8'h5A, 0, 1'b0, 3, 8'h00};
    tbl[1]  = '{1'b0, 16'h8000, 8'h00, 0, 1'b0, 5, 8'h3C};
    tbl[2]  = '{1'b0, 16'hC123, 8'h00, 0, 1'b0, 5, 8'h5A};
    tbl[3]  = '{1'b1, 16'h8000, 8'h77, 2, 1'b1, 5, 8'h00};
    tbl[4]  = '{1'b0, 16'h8000, 8'h00, 1, 1'b0, 6, 8'h77};
    tbl[5]  = '{1'b0, 16'hCFFF, 8'h00, 0, 1'b0, 5, 8'hA5};
    tbl[6]  = '{1'b0, 16'hD000, 8'h00, 0, 1'b0, 5, 8'h3C};
    tbl[7]  = '{1'b1, 16'hD000, 8'h11, 0, 1'b0, 3, 8'h00};
    tbl[8]  = '{1'b0, 16'hD000, 8'h00, 3, 1'b1, 8, 8'h11};
    tbl[9]  = '{1'b0, 16'hC000, 8'h00, 0, 1'b0, 5, 8'h5A};
    tbl[10] = '{1'b1, 16'hCFFF, 8'hE7, 1, 1'b0, 4, 8'h00};
    tbl[11] = '{1'b0, 16'hCFFF, 8'h00, 0, 1'b0, 5, 8'hE7};
    tbl[12] = '{1'b0, 16'hD000, 8'h00, 0, 1'b0, 5, 8'h11};
    tbl[13] = '{1'b0, 16'hBFFF, 8'h00, 0, 1'b0, 5, 8'hC3};

    reset = 1'b1; req = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    paused = 1'b0; vblk = 1'b0;
    repeat (2) tick();
    @(negedge clk40M);
    chk("reset_outputs", int'(|{ack, rdata, busy, pause_req, hsad, hsdi, hswe_main, hswe_video}), 0);
    tick();
    reset = 1'b0;
    idle(2, f);

    // directed vector table
    for (int i = 0; i < 14; i++) begin
      run_txn(tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].d, tbl[i].vb, 0, tbl[i].lat, tbl[i].rd);
      if (tbl[i].we) ref_mem[tbl[i].a] = tbl[i].wd;
      idle(1, f);
    end

    // long wait on vblk with pause initially dropped
    idle(70, f);
    run_txn(1'b1, 16'hC200, 8'h9D, 100, 1'b1, 0, 103, 8'h00);
    chk("pause_low_before_req", int'(p0), 0);
    ref_mem[16'hC200] = 8'h9D;
    idle(2, f);

    // back-to-back reads across the main/video boundary
    run_txn(1'b0, 16'hCFFF, 8'h00, 0, 1'b0, 0, 5, ref_rd(16'hCFFF));
    run_txn(1'b0, 16'hD000, 8'h00, 0, 1'b0, 0, 5, ref_rd(16'hD000));
    chk("pause_b2b", int'(p0), 1);
    idle(70, f);
    chk("pause_fall", f, PH + 1);

    // stray req while busy, and in the ack clock
    run_txn(1'b1, 16'hD010, 8'h42, 3, 1'b0, 2, 6, 8'h00);
    ref_mem[16'hD010] = 8'h42;
    idle(3, f);
    run_txn(1'b0, 16'hD010, 8'h00, 0, 1'b0, 5, 5, 8'h42);
    idle(3, f);

    // reset during WAIT_RD
    tick(); req = 1'b1; req_we = 1'b0; req_addr = 16'h8000; paused = 1'b1; vblk = 1'b0;
    @(negedge clk40M);
    tick(); req = 1'b0; @(negedge clk40M);
    tick(); @(negedge clk40M);
    tick(); @(negedge clk40M);
    chk("rd_busy", int'(busy), 1);
    tick(); reset = 1'b1; @(negedge clk40M);
    chk("reset_mid_zero", int'(|{ack, rdata, busy, pause_req, hsad, hsdi, hswe_main, hswe_video}), 0);
    nack = 0;
    repeat (3) begin tick(); @(negedge clk40M); nack += int'(ack); end
    tick(); reset = 1'b0; @(negedge clk40M); nack += int'(ack);
    repeat (4) begin tick(); @(negedge clk40M); nack += int'(ack | busy | hswe_main | hswe_video); end
    chk("reset_no_ack", nack, 0);
    since_ack = 1000; last_addr = '0; last_rd = '0;
    run_txn(1'b0, 16'hC123, 8'h00, 0, 1'b0, 0, 5, ref_rd(16'hC123));
    idle(2, f);

    // random transactions against the reference model
    for (int n = 0; n < 40; n++) begin
      logic        we;
      logic [15:0] a;
      logic [7:0]  wd;
      int          d, lat, xr, gap;
      logic        vb;
      we  = 1'($urandom_range(0, 1));
      a   = {his[$urandom_range(0, 5)], 8'($urandom_range(0, 7))};
      wd  = 8'($urandom);
      d   = $urandom_range(0, 4);
      vb  = 1'($urandom_range(0, 1));
      lat = 3 + d + (we ? 0 : RDL);
      xr  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0;
      run_txn(we, a, wd, d, vb, xr, lat, ref_rd(a));
      if (we) ref_mem[a] = wd;
      gap = ($urandom_range(0, 9) == 0) ? 66 : $urandom_range(0, 3);
      if (gap > 0) idle(gap, f);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
